countdown_timer_fsm: RTL and testbench
======================================

Name: countdown_timer_fsm

Overview:
- Countdown counterpart to the 6-bit up counter and its pause/resume FSM.
- Loads a start value from the switches, then decrements once per generated tick down to zero.
- Controlled by a single pause/resume key; asserts done at zero.
- Sits beside the up-counter path in the lab top level. Its count feeds the existing BCD encoder and 7-segment display chain; its state drives LEDR debug bits.

Parameters:
- TH, 50000000, CLOCK_50 cycles per tick (1 Hz at 50 MHz); benches use TH=4.
- W, 6, count width.

Ports:
- CLOCK_50  input  1  system clock, all flops on rising edge.
- RST  input  1  asynchronous, active-high reset.
- PR  input  1  pause/resume request, active-high level from inverted KEY[0]; asynchronous to CLOCK_50.
- LOAD_VAL  input  W  start value from SW[5:0].
- CNT_out  output  W  current count.
- tick  output  1  one-cycle pulse each time the divider expires while running.
- done  output  1  high while in DONE.
- state  output  2  FSM state for LEDR[2:1].

Behaviour:
- Reset (async, RST=1) forces:
  - state=IDLE, CNT_out=0, tick=0, done=0;
  - divider=0;
  - PR synchronizer flops=0.
- PR path:
  - 2-flop synchronizer, then rising-edge detect: pr_evt = sync2 & ~sync2_d.
  - PR going high before edge k produces pr_evt during cycle k+2; the state updates at edge k+2.
  - Holding PR high yields exactly one event. Bounce is not filtered; every clean rising edge is one event.
- State encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- IDLE:
  - CNT_out <= LOAD_VAL every cycle (live preview).
  - On pr_evt: if LOAD_VAL==0 go to DONE; else go to RUN, with CNT_out <= LOAD_VAL and divider <= 0.
- RUN:
  - Divider increments each cycle. At divider==TH-1: divider <= 0, tick=1 for that cycle, CNT_out <= CNT_out-1.
  - A tick that makes CNT_out 0 moves the FSM to DONE on the same edge.
  - pr_evt with no tick in the same cycle: go to PAUSE, divider held.
  - pr_evt and tick in the same cycle: the decrement is applied first. Next state is DONE if the new count is 0, else PAUSE.
- PAUSE:
  - Divider and CNT_out frozen; tick=0.
  - pr_evt returns to RUN; the divider resumes from its held value with no restart.
- DONE:
  - done=1, CNT_out=0, divider=0.
  - pr_evt returns to IDLE; the preview reload starts the next cycle.
- LOAD_VAL changes are ignored outside IDLE.
- Arithmetic: CNT_out is unsigned W-bit and never underflows; decrement only when CNT_out>0.
- Divider width: clog2(TH), with a minimum of 1.
- done and state are Moore outputs decoded from registered state. tick is registered.
- Reset mid-run or mid-pause behaves exactly as reset at power-up.

Decomposition:
- Shared package countdown_pkg:
  - state encodings IDLE/RUN/PAUSE/DONE (2-bit);
  - default TH constant.
- One sub-module, pr_sync_edge (ports CLOCK_50, RST, din, pulse): 2-flop synchronizer plus rising-edge pulse. It is reusable by the up-counter FSM's PR input.
- Top-level wiring is not part of this block.

Test Plan (TH=4):
- Reset: RST=1 mid-count → CNT_out=0, state=00, done=0, tick=0 immediately, before any clock edge.
- Basic countdown: LOAD_VAL=3, one PR pulse → state=01 after 2 edges. CNT_out 3→2→1→0 with a tick every 4 cycles. state=11 and done=1 on the edge CNT_out reaches 0; no further ticks.
- Pause/resume: LOAD_VAL=5, start, then PR after 2 ticks and 1 extra cycle → CNT_out frozen at 3, divider held at 1 for 20 cycles. Second PR → next tick 3 cycles after resume, CNT_out=2.
- Simultaneous: PR edge detected in the same cycle as the tick taking CNT_out 1→0 → state=DONE, not PAUSE. With CNT_out 2→1 instead → state=PAUSE, CNT_out=1.
- Zero load: LOAD_VAL=0, PR → IDLE→DONE directly with no tick. A further PR → IDLE; CNT_out tracks a new LOAD_VAL=7 next cycle.
- Held key: PR held high for 50 cycles in IDLE with LOAD_VAL=2 → exactly one transition to RUN. LOAD_VAL changed to 9 while in RUN → CNT_out unaffected.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and default tick period.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  // CLOCK_50 cycles per tick: 1 Hz from a 50 MHz clock.
  localparam int unsigned TH_DEFAULT = 50000000;

endpackage

// File: rtl/pr_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// single-cycle rising-edge pulse. A held-high input yields exactly one pulse.
module pr_sync_edge (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic din,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= din;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/countdown_timer_fsm.sv
// Countdown timer: loads LOAD_VAL, decrements once per divided tick to zero,
// paused/resumed by a single key; done is held while parked at zero.
module countdown_timer_fsm
  import countdown_pkg::*;
#(
  parameter int unsigned TH = TH_DEFAULT,
  parameter int unsigned W  = 6
) (
  input  logic         CLOCK_50,
  input  logic         RST,
  input  logic         PR,
  input  logic [W-1:0] LOAD_VAL,
  output logic [W-1:0] CNT_out,
  output logic         tick,
  output logic         done,
  output logic [1:0]   state
);

  localparam int unsigned    DW      = (TH > 1) ? $clog2(TH) : 1;
  localparam logic [DW-1:0]  DIV_MAX = DW'(TH - 1);

  logic          pr_evt;
  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  pr_sync_edge u_pr_sync_edge (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .din      (PR),
    .pulse    (pr_evt)
  );

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = LOAD_VAL;
        div_d = '0;
        if (pr_evt) begin
          if (LOAD_VAL == '0) state_d = DONE;
          else                state_d = RUN;
        end
      end
      RUN: begin
        // A tick coinciding with a pause request is applied before the
        // pause; reaching zero takes priority over pausing.
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - W'(1);
        end else if (!pr_evt) begin
          div_d = div_q + DW'(1);
        end
        if (cnt_d == '0)  state_d = DONE;
        else if (pr_evt)  state_d = PAUSE;
      end
      PAUSE: begin
        if (pr_evt) state_d = RUN;
      end
      DONE: begin
        cnt_d = '0;
        div_d = '0;
        if (pr_evt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign CNT_out = cnt_q;
  assign tick    = tick_q;
  assign done    = (state_q == DONE);
  assign state   = state_q;

endmodule

// File: tb/tb_countdown_timer_fsm.sv
// Directed self-checking bench for countdown_timer_fsm with a short tick period.
module tb_countdown_timer_fsm;

  logic       CLOCK_50;
  logic       RST;
  logic       PR;
  logic [5:0] LOAD_VAL;
  logic [5:0] CNT_out;
  logic       tick;
  logic       done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  countdown_timer_fsm #(.TH(4), .W(6)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .PR       (PR),
    .LOAD_VAL (LOAD_VAL),
    .CNT_out  (CNT_out),
    .tick     (tick),
    .done     (done),
    .state    (state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Single-cycle key press; returns just after the edge where the FSM reacts.
  task automatic press();
    PR = 1'b1;
    cyc();
    PR = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [5:0] cnt,
                           input logic tk, input logic dn);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_cnt"},   32'(CNT_out), 32'(cnt));
    check({tag, "_tick"},  32'(tick), 32'(tk));
    check({tag, "_done"},  32'(done), 32'(dn));
  endtask

  initial begin
    RST      = 1'b0;
    PR       = 1'b0;
    LOAD_VAL = '0;
    #1 RST = 1'b1;
    #1;
    check_all("por", 2'b00, 6'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    RST = 1'b0;

    // Basic countdown from 3
    LOAD_VAL = 6'd3;
    cyc();
    check("preview3", 32'(CNT_out), 32'd3);
    press();
    check_all("run3", 2'b01, 6'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      repeat (3) cyc();
      check("pre_tick", 32'(tick), 32'd0);
      cyc();
      check("tick", 32'(tick), 32'd1);
      check("cnt_dec", 32'(CNT_out), 32'(3 - i));
    end
    check("done_state", 32'(state), 32'd3);
    check("done_flag", 32'(done), 32'd1);
    repeat (8) cyc();
    check_all("done_hold", 2'b11, 6'd0, 1'b0, 1'b1);
    press();
    check("back_idle", 32'(state), 32'd0);

    // Pause after two ticks plus one cycle, then resume
    LOAD_VAL = 6'd5;
    press();
    check_all("run5", 2'b01, 6'd5, 1'b0, 1'b0);
    repeat (7) cyc();
    press();
    check_all("paused", 2'b10, 6'd3, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("pause_cnt", 32'(CNT_out), 32'd3);
      check("pause_tick", 32'(tick), 32'd0);
    end
    press();
    check("resumed", 32'(state), 32'd1);
    repeat (2) cyc();
    check("resume_notick", 32'(tick), 32'd0);
    check("resume_cnt3", 32'(CNT_out), 32'd3);
    cyc();
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_cnt2", 32'(CNT_out), 32'd2);

    // Asynchronous reset in the middle of a run
    RST = 1'b1;
    #2;
    check_all("midrun_rst", 2'b00, 6'd0, 1'b0, 1'b0);
    cyc();
    RST = 1'b0;

    // Pause request colliding with the final tick: DONE wins
    LOAD_VAL = 6'd1;
    press();
    check("run1", 32'(state), 32'd1);
    cyc();
    press();
    check_all("sim_done", 2'b11, 6'd0, 1'b1, 1'b1);
    press();
    check("sim_idle", 32'(state), 32'd0);

    // Pause request colliding with a non-final tick: PAUSE at count 1
    LOAD_VAL = 6'd2;
    press();
    cyc();
    press();
    check_all("sim_pause", 2'b10, 6'd1, 1'b1, 1'b0);
    repeat (5) cyc();
    check_all("sim_pause_hold", 2'b10, 6'd1, 1'b0, 1'b0);
    press();
    repeat (4) cyc();
    check_all("sim_finish", 2'b11, 6'd0, 1'b1, 1'b1);
    press();

    // Zero load goes straight to DONE
    LOAD_VAL = 6'd0;
    cyc();
    press();
    check_all("zero_done", 2'b11, 6'd0, 1'b0, 1'b1);
    press();
    check("zero_idle", 32'(state), 32'd0);
    LOAD_VAL = 6'd7;
    cyc();
    check("preview7", 32'(CNT_out), 32'd7);

    // Held key gives a single event; LOAD_VAL ignored while running
    LOAD_VAL = 6'd2;
    PR = 1'b1;
    repeat (3) cyc();
    check_all("held_run", 2'b01, 6'd2, 1'b0, 1'b0);
    LOAD_VAL = 6'd9;
    cyc();
    check("ignore_load_cnt", 32'(CNT_out), 32'd2);
    check("ignore_load_state", 32'(state), 32'd1);
    repeat (46) cyc();
    check_all("held_done", 2'b11, 6'd0, 1'b0, 1'b1);
    PR = 1'b0;
    repeat (3) cyc();
    check("release_done", 32'(state), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
